// File: rtl/div_seq_ctrl.sv
// Sequencing controller for the shared iterative radix-2 restoring divider.
// Optional early exit for |dividend| < |divisor| is enabled by defining DIV_EARLY_OUT_EN.
module div_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              div_en,
    input  logic              div_signed,
    input  logic [DATA_W-1:0] div_src1,
    input  logic [DATA_W-1:0] div_src2,
    input  logic              es_accept,
    input  logic              flush,
    output logic              div_busy,
    output logic              div_complete,
    output logic [DATA_W-1:0] div_quotient,
    output logic [DATA_W-1:0] div_remainder
);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state, next_state;

    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic              is_signed;
    logic              q_neg;
    logic              r_neg;
    logic [DATA_W-1:0] divisor;
    logic [DATA_W-1:0] work;
    logic [DATA_W-1:0] rem;
    logic [CNT_W-1:0]  cnt;

    logic [DATA_W-1:0] mag1;
    logic [DATA_W-1:0] mag2;
    logic              divisor_zero;
    logic              early_out;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic              borrow;
    logic              last_iter;
    logic              abort;
    logic [DATA_W-1:0] q_fix;
    logic [DATA_W-1:0] r_fix;

    assign mag1         = (is_signed && src1[DATA_W-1]) ? -src1 : src1;
    assign mag2         = (is_signed && src2[DATA_W-1]) ? -src2 : src2;
    assign divisor_zero = (src2 == '0);

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (mag1 < mag2);
`else
    assign early_out = 1'b0;
`endif

    // work holds the dividend on entry and collects quotient bits from the LSB as it shifts out.
    assign shifted   = {rem, work[DATA_W-1]};
    assign diff      = shifted - {1'b0, divisor};
    assign borrow    = diff[DATA_W];
    assign last_iter = (cnt == CNT_W'(DATA_W - 1));
    assign abort     = flush || !div_en;
    assign q_fix     = q_neg ? -work : work;
    assign r_fix     = r_neg ? -rem : rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (div_en && !flush) next_state = PREP;
            end
            PREP: begin
                if (abort)                          next_state = IDLE;
                else if (divisor_zero || early_out) next_state = DONE;
                else                                next_state = CALC;
            end
            CALC: begin
                if (abort)          next_state = IDLE;
                else if (last_iter) next_state = FIX;
            end
            FIX: begin
                if (abort) next_state = IDLE;
                else       next_state = DONE;
            end
            DONE: begin
                if (flush || es_accept || !div_en) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        div_busy     = 1'b0;
        div_complete = 1'b0;
        case (state)
            PREP, CALC, FIX: div_busy     = 1'b1;
            DONE:            div_complete = 1'b1;
            default: ;
        endcase
    end

    // Results only move when the controller actually lands in DONE, so an abort leaves them untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            src1          <= '0;
            src2          <= '0;
            is_signed     <= 1'b0;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            divisor       <= '0;
            work          <= '0;
            rem           <= '0;
            cnt           <= '0;
            div_quotient  <= '0;
            div_remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (next_state == PREP) begin
                        src1      <= div_src1;
                        src2      <= div_src2;
                        is_signed <= div_signed;
                    end
                end
                PREP: begin
                    q_neg   <= is_signed && (src1[DATA_W-1] ^ src2[DATA_W-1]);
                    r_neg   <= is_signed && src1[DATA_W-1];
                    divisor <= mag2;
                    work    <= mag1;
                    rem     <= '0;
                    cnt     <= '0;
                    if (next_state == DONE) begin
                        div_quotient  <= divisor_zero ? '1 : '0;
                        div_remainder <= src1;
                    end
                end
                CALC: begin
                    rem  <= borrow ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
                    work <= {work[DATA_W-2:0], ~borrow};
                    cnt  <= cnt + CNT_W'(1);
                end
                FIX: begin
                    if (next_state == DONE) begin
                        div_quotient  <= q_fix;
                        div_remainder <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: driver pushes reference results, monitor pops on div_complete.
// Honours DIV_EARLY_OUT_EN for the expected latency of short operations.
module tb_div_seq_ctrl;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              div_en;
    logic              div_signed;
    logic [DATA_W-1:0] div_src1;
    logic [DATA_W-1:0] div_src2;
    logic              es_accept;
    logic              flush;
    logic              div_busy;
    logic              div_complete;
    logic [DATA_W-1:0] div_quotient;
    logic [DATA_W-1:0] div_remainder;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          cap_edge;
        int          at_edge;
    } exp_t;

    exp_t        scoreboard[$];
    exp_t        cur_exp;
    exp_t        mon_e;
    logic        prev_complete = 1'b0;
    logic [31:0] last_q;
    logic [31:0] last_r;
    int          checks = 0;
    int          errors = 0;
    int          edge_cnt = 0;

    div_seq_ctrl #(.DATA_W(DATA_W), .CNT_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .div_en       (div_en),
        .div_signed   (div_signed),
        .div_src1     (div_src1),
        .div_src2     (div_src2),
        .es_accept    (es_accept),
        .flush        (flush),
        .div_busy     (div_busy),
        .div_complete (div_complete),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Plain-arithmetic reference: wide signed division truncates toward zero, remainder follows dividend.
    function automatic exp_t refModel(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                      input int cap_edge);
        exp_t   e;
        longint sa, sbv, ma, mb;
        bit     short_path;
        if (sgn) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
        end else begin
            sa  = longint'({32'b0, a});
            sbv = longint'({32'b0, b});
        end
        ma = (sa < 0) ? -sa : sa;
        mb = (sbv < 0) ? -sbv : sbv;
        short_path = (b == 32'h0);
        if (b == 32'h0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
        end else begin
            e.q = 32'(sa / sbv);
            e.r = 32'(sa % sbv);
        end
`ifdef DIV_EARLY_OUT_EN
        if (b != 32'h0 && ma < mb) short_path = 1'b1;
`else
        if (ma < 0 || mb < 0) short_path = 1'b0;
`endif
        e.cap_edge = cap_edge;
        e.at_edge  = cap_edge + (short_path ? 1 : DATA_W + 2);
        return e;
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            4:       return 32'h0 - 32'($urandom_range(1, 20));
            default: return $urandom();
        endcase
    endfunction

    // Called at a negedge; idle_gap counts IDLE cycles the DUT spends before it can capture.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 input int idle_gap);
        div_en     = 1'b1;
        div_src1   = a;
        div_src2   = b;
        div_signed = sgn;
        cur_exp    = refModel(a, b, sgn, edge_cnt + 1 + idle_gap);
        scoreboard.push_back(cur_exp);
    endtask

    task automatic waitComplete(output bit ok);
        int busy_cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (div_complete) begin
                ok = 1'b1;
                break;
            end
            if (div_busy) busy_cycles++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL complete_timeout: got no div_complete within 80 cycles, expected one at edge %0d",
                     cur_exp.at_edge);
        end else begin
            checkOutput("busy_cycles", 32'(busy_cycles), 32'(cur_exp.at_edge - cur_exp.cap_edge));
            last_q = cur_exp.q;
            last_r = cur_exp.r;
        end
    endtask

    task automatic finishOp(input bit b2b, input logic [31:0] a, input logic [31:0] b, input logic sgn);
        int hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("complete_hold", 32'(div_complete), 32'd1);
            checkOutput("quotient_hold", div_quotient, last_q);
        end
        es_accept = 1'b1;
        if (b2b) applyStimulus(a, b, sgn, 1);
        @(negedge clk);
        es_accept = 1'b0;
        if (!b2b) div_en = 1'b0;
    endtask

    task automatic recoverDut();
        reset     = 1'b1;
        div_en    = 1'b0;
        es_accept = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        scoreboard.delete();
        last_q = 32'h0;
        last_r = 32'h0;
        @(negedge clk);
    endtask

    task automatic doOp(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        bit ok;
        applyStimulus(a, b, sgn, 0);
        waitComplete(ok);
        if (ok) finishOp(1'b0, 32'h0, 32'h0, 1'b0);
        else    recoverDut();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (div_complete && !prev_complete) begin
            if (scoreboard.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_complete: got div_complete with q=%h r=%h, expected no completion",
                         div_quotient, div_remainder);
            end else begin
                mon_e = scoreboard.pop_front();
                checkOutput("quotient", div_quotient, mon_e.q);
                checkOutput("remainder", div_remainder, mon_e.r);
                checkOutput("complete_edge", 32'(edge_cnt), 32'(mon_e.at_edge));
            end
        end
        prev_complete = div_complete;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got simulation still running, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        reset      = 1'b1;
        div_en     = 1'b0;
        div_signed = 1'b0;
        div_src1   = 32'h0;
        div_src2   = 32'h0;
        es_accept  = 1'b0;
        flush      = 1'b0;
        last_q     = 32'h0;
        last_r     = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(div_busy), 32'd0);
        checkOutput("reset_complete", 32'(div_complete), 32'd0);
        checkOutput("reset_quotient", div_quotient, 32'h0);
        checkOutput("reset_remainder", div_remainder, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        doOp(32'd100, 32'd7, 1'b0);
        doOp(32'hFFFF_FFF9, 32'd2, 1'b1);
        doOp(32'd7, 32'hFFFF_FFFE, 1'b1);
        doOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        doOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        doOp(32'd5, 32'd0, 1'b0);

        // Flush during the 10th CALC cycle.
        applyStimulus(32'hDEAD_BEEF, 32'd3, 1'b0, 0);
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_busy", 32'(div_busy), 32'd0);
        checkOutput("flush_complete", 32'(div_complete), 32'd0);
        checkOutput("flush_keep_q", div_quotient, last_q);
        checkOutput("flush_keep_r", div_remainder, last_r);
        flush  = 1'b0;
        div_en = 1'b0;
        scoreboard.delete();
        repeat (45) @(negedge clk);
        checkOutput("flush_stays_idle", 32'(div_busy), 32'd0);

        doOp(32'd9, 32'd3, 1'b0);

        // Flush together with accept in DONE, then flush against an IDLE capture.
        applyStimulus(32'd20, 32'd3, 1'b0, 0);
        waitComplete(ok);
        if (ok) begin
            flush     = 1'b1;
            es_accept = 1'b1;
            @(negedge clk);
            checkOutput("flush_accept_busy", 32'(div_busy), 32'd0);
            checkOutput("flush_accept_complete", 32'(div_complete), 32'd0);
            es_accept = 1'b0;
            @(negedge clk);
            checkOutput("flush_blocks_capture", 32'(div_busy), 32'd0);
            flush  = 1'b0;
            div_en = 1'b0;
            @(negedge clk);
        end else begin
            recoverDut();
        end

        // Back-to-back: accept with div_en held and the next operands already presented.
        applyStimulus(32'd100, 32'd7, 1'b0, 0);
        waitComplete(ok);
        if (ok) begin
            finishOp(1'b1, 32'd50, 32'd5, 1'b0);
            waitComplete(ok);
            if (ok) finishOp(1'b0, 32'h0, 32'h0, 1'b0);
            else    recoverDut();
        end else begin
            recoverDut();
        end
        @(negedge clk);
        doOp(32'd3, 32'd100, 1'b0);

        // div_en withdrawn mid-calculation.
        applyStimulus(32'd1000, 32'd3, 1'b0, 0);
        repeat (6) @(negedge clk);
        div_en = 1'b0;
        scoreboard.delete();
        @(negedge clk);
        checkOutput("den_drop_busy", 32'(div_busy), 32'd0);
        repeat (3) @(negedge clk);

        // Reset mid-operation.
        applyStimulus(32'd12345, 32'd67, 1'b1, 0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_busy", 32'(div_busy), 32'd0);
        checkOutput("midreset_complete", 32'(div_complete), 32'd0);
        checkOutput("midreset_quotient", div_quotient, 32'h0);
        checkOutput("midreset_remainder", div_remainder, 32'h0);
        reset  = 1'b0;
        div_en = 1'b0;
        scoreboard.delete();
        last_q = 32'h0;
        last_r = 32'h0;
        @(negedge clk);

        // Randomised traffic, mixing isolated and back-to-back operations.
        applyStimulus(randOperand(), randOperand(), 1'($urandom_range(0, 1)), 0);
        for (int i = 0; i < 40; i++) begin
            waitComplete(ok);
            if (!ok) begin
                recoverDut();
                if (i < 39) applyStimulus(randOperand(), randOperand(), 1'($urandom_range(0, 1)), 0);
                continue;
            end
            if (i < 39 && $urandom_range(0, 1) == 1) begin
                finishOp(1'b1, randOperand(), randOperand(), 1'($urandom_range(0, 1)));
            end else begin
                finishOp(1'b0, 32'h0, 32'h0, 1'b0);
                if (i < 39) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    applyStimulus(randOperand(), randOperand(), 1'($urandom_range(0, 1)), 0);
                end
            end
        end

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(scoreboard.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
